// File: rtl/sys_array_matrix_loader.sv
// Streams operand matrices A and B into packed registers, then drives the
// fetcher's load_params/start_comp handshake and waits for a fresh ready edge.
module sys_array_matrix_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_W    = 5,
   parameter int ARRAY_L    = 2
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [DATA_WIDTH-1:0]                  in_data,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic                                   soft_clear,
   input  logic                                   array_ready,
   output logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0]  matrix_a,
   output logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0]  matrix_b,
   output logic                                   load_params,
   output logic                                   start_comp,
   output logic                                   busy,
   output logic                                   done
);

   localparam int N     = ARRAY_W * ARRAY_L;
   localparam int CNT_W = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      ISSUE_LOAD,
      ISSUE_START,
      WAIT_LOW,
      WAIT_HIGH
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] wr_idx;
   logic             accept;
   logic             wr_a;
   logic             wr_b;
   logic             load_params_d;
   logic             start_comp_d;
   logic             done_d;
   logic             busy_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // WAIT_LOW/WAIT_HIGH together demand a genuine low-then-high on array_ready,
   // so a ready left over from the previous run cannot end this one.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (N == 1) ? LOAD_B : LOAD_A;
            end
         end
         LOAD_A: begin
            if (accept && cnt == LAST) begin
               next_state = LOAD_B;
            end
         end
         LOAD_B: begin
            if (accept && cnt == LAST) begin
               next_state = ISSUE_LOAD;
            end
         end
         ISSUE_LOAD:  next_state = ISSUE_START;
         ISSUE_START: next_state = WAIT_LOW;
         WAIT_LOW: begin
            if (!array_ready) begin
               next_state = WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (array_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (soft_clear) begin
         next_state = IDLE;
      end
   end

   always_comb begin
      in_ready      = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
      accept        = in_valid && in_ready && !soft_clear;
      wr_a          = accept && ((state == IDLE) || (state == LOAD_A));
      wr_b          = accept && (state == LOAD_B);
      wr_idx        = (state == IDLE) ? '0 : cnt;
      load_params_d = (next_state == ISSUE_LOAD);
      start_comp_d  = (next_state == ISSUE_START);
      done_d        = (state == WAIT_HIGH) && array_ready && !soft_clear;
      busy_d        = (next_state != IDLE);
   end

   // The first word is taken in IDLE as element 0, so the counter leaves IDLE at 1.
   always_comb begin
      cnt_next = cnt;
      if (soft_clear) begin
         cnt_next = '0;
      end else if (accept) begin
         if (state == IDLE) begin
            cnt_next = (N == 1) ? '0 : CNT_W'(1);
         end else if (cnt == LAST) begin
            cnt_next = '0;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         load_params <= 1'b0;
         start_comp  <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         cnt         <= cnt_next;
         load_params <= load_params_d;
         start_comp  <= start_comp_d;
         done        <= done_d;
         busy        <= busy_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         matrix_a <= '0;
         matrix_b <= '0;
      end else begin
         for (int e = 0; e < N; e++) begin
            if (wr_a && wr_idx == CNT_W'(e)) begin
               matrix_a[e*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
            if (wr_b && wr_idx == CNT_W'(e)) begin
               matrix_b[e*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_sys_array_matrix_loader.sv
// Scoreboard bench for sys_array_matrix_loader: stimulus pushes expected pulses,
// a negedge monitor pops and checks them against a matrix-level model.
module tb_sys_array_matrix_loader;

   localparam int DW = 8;
   localparam int AW = 5;
   localparam int AL = 2;
   localparam int N  = AW * AL;
   localparam int MW = N * DW;

   logic          clk;
   logic          reset_n;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          soft_clear;
   logic          array_ready;
   logic [MW-1:0] matrix_a;
   logic [MW-1:0] matrix_b;
   logic          load_params;
   logic          start_comp;
   logic          busy;
   logic          done;

   sys_array_matrix_loader #(.DATA_WIDTH(DW), .ARRAY_W(AW), .ARRAY_L(AL)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .soft_clear(soft_clear), .array_ready(array_ready),
      .matrix_a(matrix_a), .matrix_b(matrix_b), .load_params(load_params),
      .start_comp(start_comp), .busy(busy), .done(done)
   );

   typedef struct {
      int            kind;
      int            cyc;
      logic [MW-1:0] a;
      logic [MW-1:0] b;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            k = 0;
   logic [DW-1:0] model_a[AW][AL];
   logic [DW-1:0] model_b[AW][AL];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual %h required %h", name, act, req);
      end
   endtask

   function automatic logic [MW-1:0] pack_model(input bit which_b);
      logic [MW-1:0] v;
      v = '0;
      for (int i = 0; i < AW; i++)
         for (int j = 0; j < AL; j++)
            v[(i*AL+j)*DW +: DW] = which_b ? model_b[i][j] : model_a[i][j];
      return v;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < AW; i++)
         for (int j = 0; j < AL; j++) begin
            model_a[i][j] = '0;
            model_b[i][j] = '0;
         end
   endtask

   // Sends one word (optionally preceded by idle gaps) and records it in the model.
   task automatic applyStimulus(input logic [DW-1:0] word, input bit gapped);
      if (gapped) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            checkOutput("ready_in_gap", MW'(in_ready), MW'(1));
         end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = word;
      @(posedge clk);
      if (k < N) model_a[k / AL][k % AL] = word;
      else       model_b[(k - N) / AL][(k - N) % AL] = word;
      k++;
   endtask

   task automatic run_load(input bit gapped, input bit seq_words, input int hold, input int low);
      int   t;
      int   done_edge;
      exp_t e;
      while (k < 2 * N) applyStimulus(seq_words ? DW'(k + 1) : DW'($urandom), gapped);
      #1;
      t = cyc;
      done_edge = t + 3 + hold + low;
      e.a = pack_model(1'b0);
      e.b = pack_model(1'b1);
      e.kind = 1; e.cyc = t;         exp_q.push_back(e);
      e.kind = 2; e.cyc = t + 1;     exp_q.push_back(e);
      e.kind = 3; e.cyc = done_edge; exp_q.push_back(e);
      for (int edge_n = t + 1; edge_n <= done_edge; edge_n++) begin
         @(negedge clk);
         checkOutput("ready_low_after_load", MW'(in_ready), MW'(0));
         if (edge_n <= t + 2 + hold)      array_ready = 1'b1;
         else if (edge_n < done_edge)     array_ready = 1'b0;
         else                             array_ready = 1'b1;
         in_valid = (edge_n < done_edge);
         in_data  = DW'($urandom);
      end
      begin : wait_done
         int budget;
         budget = 40;
         while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         checkOutput("pulse_timeout", MW'(exp_q.size() != 0), MW'(0));
      end
      k = 0;
   endtask

   always @(negedge clk) begin
      if (reset_n && (load_params || start_comp || done)) begin
         exp_t e;
         int   kind;
         checkOutput("pulse_exclusive", MW'(int'(load_params) + int'(start_comp) + int'(done)), MW'(1));
         kind = load_params ? 1 : (start_comp ? 2 : 3);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pulse actual kind %0d required none at cycle %0d", kind, cyc);
         end else begin
            e = exp_q.pop_front();
            checkOutput("pulse_kind", MW'(kind), MW'(e.kind));
            checkOutput("pulse_cycle", MW'(cyc), MW'(e.cyc));
            checkOutput("pulse_busy", MW'(busy), MW'(e.kind != 3));
            if (e.kind != 2) begin
               checkOutput("matrix_a", matrix_a, e.a);
               checkOutput("matrix_b", matrix_b, e.b);
            end
         end
      end
   end

   initial begin
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      soft_clear  = 1'b0;
      array_ready = 1'b1;
      clear_model();
      #2;
      checkOutput("reset_in_ready", MW'(in_ready), MW'(1));
      checkOutput("reset_busy", MW'(busy), MW'(0));
      checkOutput("reset_pulses", MW'({load_params, start_comp, done}), MW'(0));
      checkOutput("reset_matrix_a", matrix_a, '0);
      checkOutput("reset_matrix_b", matrix_b, '0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] back-to-back load");
      run_load(1'b0, 1'b1, 0, 3);
      checkOutput("a_0_0", MW'(matrix_a[7:0]), MW'(1));
      checkOutput("a_4_1", MW'(matrix_a[79:72]), MW'(10));
      checkOutput("b_0_0", MW'(matrix_b[7:0]), MW'(11));
      checkOutput("b_4_1", MW'(matrix_b[79:72]), MW'(20));
      checkOutput("idle_after_done", MW'({busy, in_ready}), MW'(2'b01));

      $display("[TB] gapped load");
      run_load(1'b1, 1'b1, $urandom_range(0, 3), $urandom_range(1, 4));

      $display("[TB] soft clear after 7 words");
      for (int w = 0; w < 7; w++) applyStimulus(DW'($urandom), 1'b0);
      @(negedge clk);
      soft_clear = 1'b1;
      in_valid   = 1'b1;
      in_data    = DW'($urandom);
      @(negedge clk);
      soft_clear = 1'b0;
      in_valid   = 1'b0;
      checkOutput("clear_busy", MW'(busy), MW'(0));
      checkOutput("clear_in_ready", MW'(in_ready), MW'(1));
      checkOutput("clear_keeps_a", matrix_a, pack_model(1'b0));
      checkOutput("clear_keeps_b", matrix_b, pack_model(1'b1));
      k = 0;
      run_load(1'b1, 1'b0, $urandom_range(0, 2), $urandom_range(1, 5));

      $display("[TB] second run with stale ready");
      run_load(1'b0, 1'b0, $urandom_range(1, 4), $urandom_range(1, 5));

      $display("[TB] reset during B load");
      for (int w = 0; w < N + 3; w++) applyStimulus(DW'($urandom), 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_in_ready", MW'(in_ready), MW'(1));
      checkOutput("midreset_busy", MW'(busy), MW'(0));
      checkOutput("midreset_pulses", MW'({load_params, start_comp, done}), MW'(0));
      checkOutput("midreset_matrix_a", matrix_a, '0);
      checkOutput("midreset_matrix_b", matrix_b, '0);
      clear_model();
      k = 0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", MW'(exp_q.size()), MW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
